// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
// State encodings, sizing constants and the two's-complement helper live here.
package div_unit_pkg;

  localparam int DIV_WIDTH    = 32;
  localparam int DIV_CNT_BITS = 6;
  localparam int DIV_CYCLES   = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Two's-complement negate when neg is set; 0x8000_0000 maps onto itself.
  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 neg);
    logic [DIV_WIDTH-1:0] res;
    if (neg) begin
      res = ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up
// on completion, stall to the hazard unit while busy, annul aborts silently.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH    = DIV_WIDTH,
  parameter int CNT_BITS = DIV_CNT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e          state_r, state_s;
  logic [CNT_BITS-1:0] cnt_r;
  logic [WIDTH-1:0]    dvd_r, dsr_r, rem_r, quo_r;
  logic                neg_q_r, neg_r_r;
  logic [WIDTH:0]      partial_s, diff_s;
  logic [WIDTH-1:0]    rem_nxt_s, quo_nxt_s;
  logic                ge_s, last_s, divz_s;

  assign divz_s = (num2 == {WIDTH{1'b0}});
  assign last_s = (cnt_r == CNT_BITS'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; annul overrides every transition.
  always_comb begin
    state_s = state_r;
    if (annul) begin
      state_s = DIV_IDLE;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            state_s = divz_s ? DIV_ZERO : DIV_RUN;
          end else begin
            state_s = DIV_IDLE;
          end
        end
        DIV_RUN: begin
          if (last_s) begin
            state_s = DIV_DONE;
          end else begin
            state_s = DIV_RUN;
          end
        end
        DIV_ZERO: state_s = DIV_DONE;
        DIV_DONE: state_s = DIV_IDLE;
        default:  state_s = DIV_IDLE;
      endcase
    end
  end

  // One restoring step; partial keeps a guard bit so divisors above 2^31 stay exact.
  always_comb begin
    partial_s = {rem_r, dvd_r[WIDTH-1]};
    diff_s    = partial_s - {1'b0, dsr_r};
    ge_s      = ~diff_s[WIDTH];
    if (ge_s) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
    end else begin
      rem_nxt_s = partial_s[WIDTH-1:0];
    end
    quo_nxt_s = {quo_r[WIDTH-2:0], ge_s};
  end

  // Datapath: operand capture, shift/subtract, result fix-up on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CNT_BITS{1'b0}};
      dvd_r     <= {WIDTH{1'b0}};
      dsr_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start && !annul) begin
            cnt_r   <= {CNT_BITS{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            neg_q_r <= signed_div & (num1[WIDTH-1] ^ num2[WIDTH-1]);
            neg_r_r <= signed_div & num1[WIDTH-1];
            // Divide-by-zero hands the raw dividend back as the remainder.
            dvd_r   <= divz_s ? num1 : cond_neg(num1, signed_div & num1[WIDTH-1]);
            dsr_r   <= cond_neg(num2, signed_div & num2[WIDTH-1]);
          end
        end
        DIV_RUN: begin
          if (!annul) begin
            cnt_r <= cnt_r + CNT_BITS'(1);
            dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            if (last_s) begin
              quotient  <= cond_neg(quo_nxt_s, neg_q_r);
              remainder <= cond_neg(rem_nxt_s, neg_r_r);
            end
          end
        end
        DIV_ZERO: begin
          if (!annul) begin
            quotient  <= {WIDTH{1'b1}};
            remainder <= dvd_r;
          end
        end
        DIV_DONE: begin
          cnt_r <= {CNT_BITS{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_BITS{1'b0}};
        end
      endcase
    end
  end

  // Handshake to the hazard unit and the HI/LO write path.
  always_comb begin
    stall = 1'b0;
    valid = 1'b0;
    if (annul) begin
      stall = 1'b0;
      valid = 1'b0;
    end else begin
      stall = (start && state_r == DIV_IDLE) || state_r == DIV_RUN || state_r == DIV_ZERO;
      valid = (state_r == DIV_DONE);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of hand-computed divisions plus annul/reset sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] num1, num2;
  logic        stall, valid;
  logic [31:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .num1(num1), .num2(num2), .stall(stall), .valid(valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at posedge+1 (start of cycle 0). start is held while stall is seen high.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int vcyc, output int nstall,
                        output logic [31:0] q, output logic [31:0] r);
    logic st;
    vcyc = -1; nstall = 0; q = 32'h0; r = 32'h0;
    signed_div = s; num1 = a; num2 = b; start = 1'b1;
    for (int c = 0; c < 60 && vcyc < 0; c++) begin
      @(negedge clk);
      st = stall;
      if (stall) nstall++;
      if (valid) begin
        vcyc = c; q = quotient; r = remainder;
      end
      @(posedge clk); #1;
      if (!st) start = 1'b0;
    end
    start = 1'b0;
  endtask

  int          vc, ns, seen;
  logic [31:0] q, r, pq, pr;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  2};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  2};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  33};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          33};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; num1 = 32'h0; num2 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q", quotient, 32'h0);
    chk("reset_r", remainder, 32'h0);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vc, ns, q, r);
      chk($sformatf("v%0d_latency", i), vc, vecs[i].lat);
      chk($sformatf("v%0d_stalls", i), ns, vecs[i].lat);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_r", i), r, vecs[i].r);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'h0, valid}, 32'h0);
      @(posedge clk); #1;
    end

    // Annul in cycle 10 of a run: no pulse, results untouched, restart at cycle 12.
    pq = quotient; pr = remainder; seen = 0;
    signed_div = 1'b0; num1 = 32'd100; num2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk); if (valid) seen++;
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(negedge clk);
    chk("annul_stall_low", {31'h0, stall}, 32'h0);
    @(posedge clk); #1; annul = 1'b0;
    @(negedge clk);
    if (valid) seen++;
    chk("annul_idle_stall", {31'h0, stall}, 32'h0);
    chk("annul_q_kept", quotient, pq);
    chk("annul_r_kept", remainder, pr);
    @(posedge clk); #1;
    run_op(1'b0, 32'd9, 32'd3, vc, ns, q, r);
    chk("annul_no_valid", seen, 0);
    chk("restart_latency", vc + 12, 45);
    chk("restart_q", q, 32'd3);
    chk("restart_r", r, 32'd0);

    // Async reset between edges mid-run.
    run_op(1'b0, 32'h0000_1234, 32'd0, vc, ns, q, r);
    signed_div = 1'b0; num1 = 32'd100; num2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_q_zero", quotient, 32'h0);
    chk("rst_r_zero", remainder, 32'h0);
    chk("rst_stall_zero", {31'h0, stall}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); if (valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst_no_valid", seen, 0);

    // start and annul together in IDLE: annul wins, nothing launches.
    signed_div = 1'b0; num1 = 32'd100; num2 = 32'd7; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk("start_annul_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1; start = 1'b0; annul = 1'b0;
    seen = 0; ns = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid) seen++;
      if (stall) ns++;
      @(posedge clk); #1;
    end
    chk("start_annul_no_valid", seen, 0);
    chk("start_annul_no_stall", ns, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
